// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder sequencing one full_adder cell LSB-first over WIDTH cycles
// Optional subtract mode (sub port, a - b) enabled by defining SERIAL_ADDER_SUB_EN.

module full_adder (
   input  logic A,
   input  logic B,
   input  logic C,
   output logic sum,
   output logic carry
);
   assign sum   = A ^ B ^ C;
   assign carry = (A & B) | (A & C) | (B & C);
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] op_a, op_b, partial;
   logic             carry;
   logic [CW-1:0]    count;
   logic             fa_sum, fa_carry;
   logic             load, last;
   logic [WIDTH-1:0] b_load;
   logic             carry_load;

`ifdef SERIAL_ADDER_SUB_EN
   // Two's-complement subtract: invert B and force the carry-in to 1.
   assign b_load     = sub ? ~b : b;
   assign carry_load = sub ? 1'b1 : cin;
`else
   assign b_load     = b;
   assign carry_load = cin;
`endif

   assign last = (count == CW'(WIDTH-1));

   full_adder u_fa (
      .A     (op_a[0]),
      .B     (op_b[0]),
      .C     (carry),
      .sum   (fa_sum),
      .carry (fa_carry)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      load       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last) state_next = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               load       = 1'b1;
               state_next = RUN;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_a    <= '0;
         op_b    <= '0;
         partial <= '0;
         carry   <= 1'b0;
         count   <= '0;
         sum     <= '0;
         cout    <= 1'b0;
      end else if (load) begin
         op_a  <= a;
         op_b  <= b_load;
         carry <= carry_load;
         count <= '0;
      end else if (state == RUN) begin
         op_a    <= op_a >> 1;
         op_b    <= op_b >> 1;
         partial <= {fa_sum, partial[WIDTH-1:1]};
         carry   <= fa_carry;
         if (last) begin
            sum  <= {fa_sum, partial[WIDTH-1:1]};
            cout <= fa_carry;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - directed vector bench for serial_adder_ctrl (WIDTH=8)

module tb_serial_adder_ctrl;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a, b;
   logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
   logic             sub;
`endif
   logic             busy, done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   int errors = 0;
   int checks = 0;

   serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] va;
      logic [7:0] vb;
      logic       vcin;
      logic [7:0] exp_sum;
      logic       exp_cout;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues a one-cycle start and waits (bounded) for done; reports latency and busy cycles.
   task automatic do_op(input logic [7:0] ta, input logic [7:0] tbv, input logic tc,
                        output int lat, output int busy_cnt, output int overlap);
      a = ta; b = tbv; cin = tc; start = 1'b1;
      tick();
      start = 1'b0;
      lat = 0; busy_cnt = 0; overlap = 0;
      while (!done && lat < 20) begin
         if (busy) busy_cnt++;
         tick();
         lat++;
      end
      if (busy && done) overlap++;
   endtask

   int lat, bc, ov;
   int done_cnt, last_done, spacing_bad, consec, both, stable_bad;
   logic prev_done;

   initial begin
      vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      vecs[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
      vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
      vecs[5] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
      vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
      vecs[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};

      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub = 1'b0;
`endif
      tick(); tick();
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_sum", sum, 0);
      check("reset_cout", cout, 0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 8; i++) begin
         do_op(vecs[i].va, vecs[i].vb, vecs[i].vcin, lat, bc, ov);
         check($sformatf("v%0d_latency", i), lat, WIDTH);
         check($sformatf("v%0d_busy_cycles", i), bc, WIDTH);
         check($sformatf("v%0d_busy_done_overlap", i), ov, 0);
         check($sformatf("v%0d_sum", i), sum, vecs[i].exp_sum);
         check($sformatf("v%0d_cout", i), cout, vecs[i].exp_cout);
         tick();
         check($sformatf("v%0d_done_one_cycle", i), done, 0);
      end

      // Result stability: 8'h96 must hold through the next operation until it completes.
      do_op(8'h5A, 8'h3C, 1'b0, lat, bc, ov);
      check("stab_first_sum", sum, 8'h96);
      tick();
      a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      stable_bad = 0; lat = 0;
      while (!done && lat < 20) begin
         if (sum != 8'h96) stable_bad++;
         tick();
         lat++;
      end
      check("stab_hold_cycles_bad", stable_bad, 0);
      check("stab_latency", lat, WIDTH);
      check("stab_new_sum", sum, 8'h02);
      tick();

      // start pulses during RUN with different operands must be ignored.
      a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      lat = 3;
      while (!done && lat < 20) begin
         tick();
         lat++;
      end
      check("ignore_start_latency", lat, WIDTH);
      check("ignore_start_sum", sum, 8'h96);
      check("ignore_start_cout", cout, 0);
      tick(); tick();

      // start held high for 30 cycles: done every WIDTH+1 cycles.
      a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
      done_cnt = 0; last_done = -1; spacing_bad = 0; consec = 0; both = 0; prev_done = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         tick();
         if (busy && done) both++;
         if (done && prev_done) consec++;
         if (done) begin
            if (last_done >= 0 && (k - last_done) != WIDTH + 1) spacing_bad++;
            if (last_done < 0 && k != WIDTH + 1) spacing_bad++;
            last_done = k;
            done_cnt++;
         end
         prev_done = done;
      end
      start = 1'b0;
      check("held_done_count", done_cnt, 3);
      check("held_spacing_bad", spacing_bad, 0);
      check("held_consecutive_done", consec, 0);
      check("held_busy_and_done", both, 0);
      check("held_sum", sum, 8'h02);
      tick(); tick(); tick();

      // Reset 4 cycles into RUN aborts the operation.
      a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_sum", sum, 0);
      check("abort_cout", cout, 0);
      done_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         if (done || busy) done_cnt++;
         tick();
      end
      check("abort_no_activity", done_cnt, 0);
      do_op(8'hFF, 8'h01, 1'b0, lat, bc, ov);
      check("abort_fresh_latency", lat, WIDTH);
      check("abort_fresh_sum", sum, 8'h00);
      check("abort_fresh_cout", cout, 1);
      tick();

      // Simultaneous rst and start: reset wins.
      a = 8'h12; b = 8'h34; cin = 1'b1; start = 1'b1; rst = 1'b1;
      tick();
      start = 1'b0; rst = 1'b0;
      check("rst_start_busy", busy, 0);
      check("rst_start_sum", sum, 0);
      tick();
      check("rst_start_still_idle", busy, 0);

`ifdef SERIAL_ADDER_SUB_EN
      sub = 1'b1;
      do_op(8'h10, 8'h01, 1'b0, lat, bc, ov);
      check("sub_10_01_sum", sum, 8'h0F);
      check("sub_10_01_cout", cout, 1);
      tick();
      do_op(8'h00, 8'h01, 1'b1, lat, bc, ov);
      check("sub_00_01_sum", sum, 8'hFF);
      check("sub_00_01_cout", cout, 0);
      sub = 1'b0;
      tick();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
